// File: rtl/nf_uart_bus_master_if.sv
// Bus-side signals of the UART bus master: address, write strobe/data and read data.
interface nf_uart_bus_master_if;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;

   modport master (output addr, output we, output wd, input rd);
   modport slave  (input addr, input we, input wd, output rd);
endinterface

// File: rtl/nf_uart_bus_master.sv
// UART-driven bus master: 'W' addr4 data4 -> write + 'K', 'R' addr4 -> 4 read bytes, else '?'.
// Define NF_UART_BM_TIMEOUT_EN to abandon ADDR/DATA after TIMEOUT cycles without a byte.
//
// state   | meaning
// S_IDLE  | waiting for a command byte
// S_ADDR  | collecting 4 address bytes, MSB first
// S_DATA  | collecting 4 write-data bytes, MSB first
// S_WRITE | one-cycle bus write strobe
// S_READ  | address held one cycle, rd captured on exit
// S_RESP  | transmitting queued response bytes
module nf_uart_bus_master #(
   parameter int DIV     = 434,
   parameter int TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic uart_rx,
   output logic uart_tx,
   output logic busy,
   nf_uart_bus_master_if.master bus
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WRITE, S_READ, S_RESP} cmd_state_t;

   rx_state_t  rx_state, rx_state_nxt;
   tx_state_t  tx_state, tx_state_nxt;
   cmd_state_t state, state_nxt;

   logic          rx_s1, rx_s2, rx_s3;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_valid;

   logic [CW-1:0] tx_cnt;
   logic [3:0]    tx_bit;
   logic [8:0]    tx_frame;
   logic [31:0]   q_data;
   logic [2:0]    q_count;
   logic          tx_load;

   logic [1:0]  byte_cnt, byte_cnt_nxt;
   logic        is_wr, is_wr_nxt;
   logic [31:0] addr_q, addr_nxt, wd_q, wd_nxt;
   logic        resp_load;
   logic [31:0] resp_data;
   logic [2:0]  resp_count;
   logic        to_expired;

   // ---------------- receiver ----------------
   always_comb begin
      rx_state_nxt = rx_state;
      case (rx_state)
         RX_IDLE:  if (!rx_s2 && rx_s3) rx_state_nxt = RX_START;
         RX_START: if (rx_cnt == '0) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (rx_cnt == '0 && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
         RX_STOP:  if (rx_cnt == '0) rx_state_nxt = RX_IDLE;
         default:  rx_state_nxt = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_state <= RX_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_valid <= 1'b0;
      end else begin
         rx_s1    <= uart_rx;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         rx_state <= rx_state_nxt;
         rx_valid <= 1'b0;
         case (rx_state)
            RX_IDLE: rx_cnt <= CW'(DIV / 2 - 1);
            RX_START: begin
               if (rx_cnt == '0) begin
                  rx_cnt <= CW'(DIV - 1);
                  rx_bit <= '0;
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == '0) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  rx_cnt   <= CW'(DIV - 1);
               end else begin
                  rx_cnt <= rx_cnt - 1'b1;
               end
            end
            RX_STOP: begin
               // a low stop bit is a framing error: the byte is silently dropped
               if (rx_cnt == '0) rx_valid <= rx_s2;
               else              rx_cnt   <= rx_cnt - 1'b1;
            end
            default: rx_cnt <= '0;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   assign tx_load = (q_count != '0) &&
                    ((tx_state == TX_IDLE) || (tx_cnt == '0 && tx_bit == '0));

   always_comb begin
      tx_state_nxt = tx_state;
      case (tx_state)
         TX_IDLE: if (q_count != '0) tx_state_nxt = TX_SEND;
         TX_SEND: if (tx_cnt == '0 && tx_bit == '0 && q_count == '0) tx_state_nxt = TX_IDLE;
         default: tx_state_nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= TX_IDLE;
         uart_tx  <= 1'b1;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_frame <= '1;
         q_data   <= '0;
         q_count  <= '0;
      end else begin
         tx_state <= tx_state_nxt;
         if (tx_load) begin
            // next byte starts right at the end of the previous stop bit
            uart_tx  <= 1'b0;
            tx_frame <= {1'b1, q_data[31:24]};
            tx_bit   <= 4'd9;
            tx_cnt   <= CW'(DIV - 1);
            q_data   <= {q_data[23:0], 8'h00};
            q_count  <= q_count - 3'd1;
         end else if (tx_state == TX_SEND) begin
            if (tx_cnt != '0) begin
               tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_bit != '0) begin
               uart_tx  <= tx_frame[0];
               tx_frame <= {1'b1, tx_frame[8:1]};
               tx_bit   <= tx_bit - 4'd1;
               tx_cnt   <= CW'(DIV - 1);
            end
         end
         if (resp_load) begin
            q_data  <= resp_data;
            q_count <= resp_count;
         end
      end
   end

   // ---------------- command FSM ----------------
`ifdef NF_UART_BM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_cnt <= '0;
      else if (rx_valid || !(state == S_ADDR || state == S_DATA))
         to_cnt <= TW'(TIMEOUT - 1);
      else if (to_cnt != '0)
         to_cnt <= to_cnt - 1'b1;
   end

   assign to_expired = (state == S_ADDR || state == S_DATA) && (to_cnt == '0);
`else
   // ADDR/DATA wait indefinitely for the next byte
   assign to_expired = (TIMEOUT < 0);
`endif

   always_comb begin
      state_nxt    = state;
      byte_cnt_nxt = byte_cnt;
      is_wr_nxt    = is_wr;
      addr_nxt     = addr_q;
      wd_nxt       = wd_q;
      resp_load    = 1'b0;
      resp_data    = '0;
      resp_count   = '0;
      case (state)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_shift == 8'h57 || rx_shift == 8'h52) begin
                  state_nxt    = S_ADDR;
                  byte_cnt_nxt = '0;
                  is_wr_nxt    = (rx_shift == 8'h57);
               end else begin
                  state_nxt  = S_RESP;
                  resp_load  = 1'b1;
                  resp_data  = {8'h3F, 24'h0};
                  resp_count = 3'd1;
               end
            end
         end
         S_ADDR: begin
            if (rx_valid) begin
               addr_nxt     = {addr_q[23:0], rx_shift};
               byte_cnt_nxt = byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) state_nxt = is_wr ? S_DATA : S_READ;
            end else if (to_expired) begin
               state_nxt = S_IDLE;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               wd_nxt       = {wd_q[23:0], rx_shift};
               byte_cnt_nxt = byte_cnt + 2'd1;
               if (byte_cnt == 2'd3) state_nxt = S_WRITE;
            end else if (to_expired) begin
               state_nxt = S_IDLE;
            end
         end
         S_WRITE: begin
            state_nxt  = S_RESP;
            resp_load  = 1'b1;
            resp_data  = {8'h4B, 24'h0};
            resp_count = 3'd1;
         end
         S_READ: begin
            state_nxt  = S_RESP;
            resp_load  = 1'b1;
            resp_data  = bus.rd;
            resp_count = 3'd4;
         end
         S_RESP: begin
            if (tx_state == TX_IDLE && q_count == '0) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         byte_cnt <= '0;
         is_wr    <= 1'b0;
         addr_q   <= '0;
         wd_q     <= '0;
      end else begin
         state    <= state_nxt;
         byte_cnt <= byte_cnt_nxt;
         is_wr    <= is_wr_nxt;
         addr_q   <= addr_nxt;
         wd_q     <= wd_nxt;
      end
   end

   assign bus.addr = addr_q;
   assign bus.wd   = wd_q;
   assign bus.we   = (state == S_WRITE);
   assign busy     = (state != S_IDLE) || (tx_state != TX_IDLE) || (q_count != '0);

endmodule
